// File: rtl/ddp_pipe_pkg.sv
// ddp_pipe_pkg: shared definitions for the clocked CX/C pipeline.
//   cx_state_t : CX stage FSM states (IDLE, ONE, TWO)
//   ACT / IDL  : active-low handshake levels (ACT = asserted)
//   half_swap  : exchange upper and lower halves of a width-bit word
package ddp_pipe_pkg;

  typedef enum logic [1:0] {IDLE, ONE, TWO} cx_state_t;

  localparam logic ACT = 1'b0;
  localparam logic IDL = 1'b1;

  // Widest packet half_swap can handle; callers zero-extend into this width.
  localparam int unsigned MAX_W = 256;

  function automatic logic [MAX_W-1:0] half_swap(input logic [MAX_W-1:0] data,
                                                  input int unsigned       width);
    logic [MAX_W-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < width / 2)
        res[i] = data[i + width / 2];
      else if (i < width)
        res[i] = data[i - width / 2];
    end
    return res;
  endfunction

endpackage

// File: rtl/cx_pipe_c_stage.sv
// c_stage: one-entry pipeline register stage with active-low Send/Ack.
//   clk, rst           : clock, synchronous active-high reset
//   send_prev, din,
//   feb_in, ack_prev   : upstream side (ack_prev driven here)
//   send, dout,
//   feb_out, ack_next  : downstream side (ack_next from the next stage)
//   cp                 : active-high pulse in the cycle this stage captures
module c_stage
  import ddp_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              send_prev,
  input  logic [DATA_W-1:0] din,
  input  logic              feb_in,
  output logic              ack_prev,
  output logic              send,
  output logic [DATA_W-1:0] dout,
  output logic              feb_out,
  input  logic              ack_next,
  output logic              cp
);

  logic full;
  logic ready;
  logic capture;

  // Ready when empty, or when the held entry leaves on this same edge.
  assign ready    = !full || (ack_next == ACT);
  assign capture  = (send_prev == ACT) && ready;
  assign ack_prev = ready ? ACT : IDL;
  assign send     = full ? ACT : IDL;
  assign cp       = capture && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      full    <= 1'b0;
      dout    <= '0;
      feb_out <= IDL;
    end else if (capture) begin
      full    <= 1'b1;
      dout    <= din;
      feb_out <= feb_in;
    end else if (ack_next == ACT) begin
      full    <= 1'b0;
    end
  end

endmodule

// File: rtl/cx_pipe.sv
// cx_pipe: copy/exchange front stage (CX) followed by DEPTH-1 one-entry C stages.
//   CLK, MR          : clock, synchronous active-high reset
//   Send_in, Din,
//   cpy, exb, Ack_out: upstream handshake (active-low); cpy=0 duplicates the
//                      packet, exb=0 swaps its halves
//   Send_out, Dout,
//   feb, Ack_in      : downstream handshake (active-low); feb=0 marks the copy
//   CP               : per-stage capture pulse, bit 0 is the CX stage
//   occ              : count of full stages (only with CX_OCC_EN defined)
module cx_pipe
  import ddp_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              CLK,
  input  logic              MR,
  input  logic              Send_in,
  input  logic [DATA_W-1:0] Din,
  input  logic              cpy,
  input  logic              exb,
  output logic              Ack_out,
  output logic              Send_out,
  output logic [DATA_W-1:0] Dout,
  output logic              feb,
  input  logic              Ack_in,
  output logic [DEPTH-1:0]  CP
`ifdef CX_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

  cx_state_t         state;
  logic [DATA_W-1:0] cx_data;
  logic              cx_feb;
  logic              copy_req;
  logic              cx_ready;
  logic              cx_xfer;
  logic              accept;
  logic [DATA_W-1:0] cx_din;

  // Index 0 is the CX stage; ack_c[i] is the Ack presented to stage i-1.
  logic              send_c [DEPTH];
  logic [DATA_W-1:0] data_c [DEPTH];
  logic              feb_c  [DEPTH];
  logic              ack_c  [1:DEPTH];
  logic [DEPTH-1:0]  cp_v;

  assign send_c[0]    = (state != IDLE) ? ACT : IDL;
  assign data_c[0]    = cx_data;
  assign feb_c[0]     = cx_feb;
  assign ack_c[DEPTH] = Ack_in;

  assign cx_xfer = (send_c[0] == ACT) && (ack_c[1] == ACT);
  assign cx_din  = exb == ACT ? DATA_W'(half_swap(MAX_W'(Din), DATA_W)) : Din;

  // A copying packet in ONE must stay for its second transfer, so it is not
  // ready even when the first instance leaves.
  always_comb begin
    cx_ready = 1'b0;
    case (state)
      IDLE:    cx_ready = 1'b1;
      ONE:     cx_ready = cx_xfer && !copy_req;
      TWO:     cx_ready = cx_xfer;
      default: cx_ready = 1'b0;
    endcase
  end

  assign accept  = !MR && (Send_in == ACT) && cx_ready;
  assign cp_v[0] = accept;

  always_ff @(posedge CLK) begin
    if (MR) begin
      state    <= IDLE;
      cx_data  <= '0;
      cx_feb   <= IDL;
      copy_req <= 1'b0;
    end else begin
      if (accept) begin
        cx_data  <= cx_din;
        copy_req <= (cpy == ACT);
      end
      case (state)
        IDLE: if (accept) state <= ONE;
        ONE: begin
          if (cx_xfer) begin
            if (copy_req) begin
              state  <= TWO;
              cx_feb <= ACT;
            end else begin
              state  <= accept ? ONE : IDLE;
            end
          end
        end
        TWO: begin
          if (cx_xfer) begin
            state  <= accept ? ONE : IDLE;
            cx_feb <= IDL;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 1; i < DEPTH; i++) begin : g_c
    c_stage #(.DATA_W(DATA_W)) u_c (
      .clk      (CLK),
      .rst      (MR),
      .send_prev(send_c[i-1]),
      .din      (data_c[i-1]),
      .feb_in   (feb_c[i-1]),
      .ack_prev (ack_c[i]),
      .send     (send_c[i]),
      .dout     (data_c[i]),
      .feb_out  (feb_c[i]),
      .ack_next (ack_c[i+1]),
      .cp       (cp_v[i])
    );
  end

  assign Ack_out  = (!MR && cx_ready) ? ACT : IDL;
  assign Send_out = MR ? IDL : send_c[DEPTH-1];
  assign Dout     = MR ? '0 : data_c[DEPTH-1];
  assign feb      = MR ? IDL : feb_c[DEPTH-1];
  assign CP       = MR ? '0 : cp_v;

`ifdef CX_OCC_EN
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic spawn;
  logic out_xfer;

  // The first transfer of a copied packet adds an entry downstream while the
  // CX stage stays occupied (TWO).
  assign spawn    = cx_xfer && (state == ONE) && copy_req;
  assign out_xfer = (send_c[DEPTH-1] == ACT) && (Ack_in == ACT);

  always_ff @(posedge CLK) begin
    if (MR)
      occ <= '0;
    else
      occ <= occ + OCC_W'(accept) + OCC_W'(spawn) - OCC_W'(out_xfer);
  end
`endif

endmodule

// File: tb/tb_cx_pipe.sv
// tb_cx_pipe: directed and random-handshake bench for cx_pipe (DATA_W=16,
// DEPTH=4), with a scoreboard following every accepted and delivered packet.
module tb_cx_pipe;

  localparam int DW = 16;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          MR, Send_in, cpy, exb, Ack_in;
  logic [DW-1:0] Din;
  logic          Ack_out, Send_out, feb;
  logic [DW-1:0] Dout;
  logic [DP-1:0] CP;
`ifdef CX_OCC_EN
  logic [$clog2(DP+1)-1:0] occ;
`endif

  cx_pipe #(.DATA_W(DW), .DEPTH(DP)) dut (
    .CLK(clk), .MR(MR), .Send_in(Send_in), .Din(Din), .cpy(cpy), .exb(exb),
    .Ack_out(Ack_out), .Send_out(Send_out), .Dout(Dout), .feb(feb),
    .Ack_in(Ack_in), .CP(CP)
`ifdef CX_OCC_EN
    , .occ(occ)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Scoreboard: {feb, data} expected in delivery order.
  logic [DW:0]   q[$];
  logic [DW-1:0] out_d[$];
  int            out_c[$];
  int            cp_cnt[DP];
  int            cyc = 0;

  always @(negedge clk) begin
    logic [DW-1:0] d;
    logic [DW:0]   e;
    cyc++;
    if (MR) begin
      q.delete();
    end else begin
      for (int i = 0; i < DP; i++) if (CP[i]) cp_cnt[i]++;
      if (Send_in == 1'b0 && Ack_out == 1'b0) begin
        d = exb ? Din : {Din[7:0], Din[15:8]};
        q.push_back({1'b1, d});
        if (!cpy) q.push_back({1'b0, d});
      end
      if (Send_out == 1'b0 && Ack_in == 1'b0) begin
        out_d.push_back(Dout);
        out_c.push_back(cyc);
        if (q.size() == 0) check("sb_extra_out", 0, 1);
        else begin
          e = q.pop_front();
          check("sb_data", Dout, e[DW-1:0]);
          check("sb_feb", feb, e[DW]);
        end
      end
    end
  end

  task automatic send_one(input logic [DW-1:0] d, input logic c, input logic x);
    int n = 0;
    Send_in = 1'b0; Din = d; cpy = c; exb = x;
    do begin @(negedge clk); n++; end while (Ack_out !== 1'b0 && n < 40);
    check("send_accept", Ack_out, 0);
    @(posedge clk); #1;
    Send_in = 1'b1; cpy = 1'b1; exb = 1'b1;
  endtask

  // Edges from acceptance to the first cycle with Send_out low; -1 on timeout.
  task automatic wait_out(output int edges);
    int n = 0;
    do begin @(negedge clk); n++; end while (Send_out !== 1'b0 && n < 40);
    edges = (Send_out === 1'b0) ? n - 1 : -1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e, acc, exp_out, guard;
    logic holding;
    MR = 1'b1; Send_in = 1'b1; Din = '0; cpy = 1'b1; exb = 1'b1; Ack_in = 1'b0;

    // Reset with random upstream activity
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      Send_in = 1'($urandom_range(1, 0)); Din = 16'($urandom);
      @(negedge clk);
      check("rst_send_out", Send_out, 1);
      check("rst_ack_out", Ack_out, 1);
      check("rst_cp", CP, 0);
    end
    @(posedge clk); #1;
    MR = 1'b0; Send_in = 1'b1;
    send_one(16'h1234, 1'b1, 1'b1);
    wait_out(e);
    check("first_latency", e, DP - 1);
    check("first_data", Dout, 16'h1234);
    check("first_feb", feb, 1);

    // Exchange
    @(posedge clk); #1;
    send_one(16'hAB12, 1'b1, 1'b0);
    wait_out(e);
    check("exb_latency", e, DP - 1);
    check("exb_data", Dout, 16'h12AB);
    check("exb_feb", feb, 1);
    for (int i = 0; i < 5; i++) begin @(negedge clk); check("exb_single", Send_out, 1); end

    // Copy under stall
    @(posedge clk); #1;
    Ack_in = 1'b1;
    send_one(16'h00F0, 1'b0, 1'b1);
    @(negedge clk); check("cpy_ack_hold", Ack_out, 1);
    @(negedge clk); check("cpy_ack_free", Ack_out, 0);
    repeat (8) @(negedge clk);
    check("cpy_stall_send", Send_out, 0);
    check("cpy_stall_data", Dout, 16'h00F0);
    check("cpy_stall_feb", feb, 1);
`ifdef CX_OCC_EN
    check("cpy_stall_occ", occ, 2);
`endif
    @(posedge clk); #1;
    Ack_in = 1'b0;
    @(negedge clk);
    check("cpy_out1_send", Send_out, 0);
    check("cpy_out1_feb", feb, 1);
    @(negedge clk);
    check("cpy_out2_send", Send_out, 0);
    check("cpy_out2_data", Dout, 16'h00F0);
    check("cpy_out2_feb", feb, 0);
    for (int i = 0; i < 5; i++) begin @(negedge clk); check("cpy_no_third", Send_out, 1); end
`ifdef CX_OCC_EN
    check("cpy_occ_empty", occ, 0);
`endif

    // Streaming 0..7 back-to-back
    @(posedge clk); #1;
    out_d.delete(); out_c.delete();
    for (int i = 0; i < DP; i++) cp_cnt[i] = 0;
    for (int j = 0; j < 8; j++) begin
      Send_in = 1'b0; Din = 16'(j);
      @(negedge clk); check("stream_ack", Ack_out, 0);
      @(posedge clk); #1;
    end
    Send_in = 1'b1;
    repeat (8) @(negedge clk);
    check("stream_count", out_d.size(), 8);
    for (int j = 0; j < 8 && j < out_d.size(); j++) begin
      check("stream_data", out_d[j], 16'(j));
      if (j > 0) check("stream_gap", out_c[j] - out_c[j-1], 1);
    end
    for (int i = 0; i < DP; i++) check("stream_cp", cp_cnt[i], 8);

    // Random back-pressure
    @(posedge clk); #1;
    out_d.delete(); out_c.delete();
    acc = 0; exp_out = 0; guard = 0; holding = 1'b0;
    while (acc < 200 && guard < 5000) begin
      if (!holding) begin
        if ($urandom_range(3, 0) != 0) begin
          holding = 1'b1; Send_in = 1'b0; Din = 16'($urandom);
          cpy = ($urandom_range(3, 0) != 0); exb = 1'($urandom_range(1, 0));
        end else begin
          Send_in = 1'b1; cpy = 1'($urandom_range(1, 0)); exb = 1'($urandom_range(1, 0));
        end
      end
      Ack_in = ($urandom_range(2, 0) == 0);
      @(negedge clk);
      if (holding && Ack_out == 1'b0) begin
        holding = 1'b0; acc++; exp_out += cpy ? 1 : 2;
      end
      @(posedge clk); #1;
      if (!holding) Send_in = 1'b1;
      guard++;
    end
    Send_in = 1'b1; cpy = 1'b1; exb = 1'b1; Ack_in = 1'b0;
    repeat (20) @(negedge clk);
    check("rand_accepted", acc, 200);
    check("rand_out_count", out_d.size(), exp_out);
    check("rand_drained", q.size(), 0);
`ifdef CX_OCC_EN
    check("rand_occ_empty", occ, 0);
`endif

    // Mid-flight reset
    @(posedge clk); #1;
    Ack_in = 1'b1;
    send_one(16'h0101, 1'b1, 1'b1);
    send_one(16'h0202, 1'b1, 1'b1);
    send_one(16'h0303, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check("mid_stalled", Send_out, 0);
    @(posedge clk); #1;
    MR = 1'b1;
    @(negedge clk);
    check("mid_rst_send", Send_out, 1);
    check("mid_rst_ack", Ack_out, 1);
    check("mid_rst_dout", Dout, 0);
    check("mid_rst_feb", feb, 1);
    @(posedge clk); #1;
    MR = 1'b0; Ack_in = 1'b0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); check("mid_dropped", Send_out, 1); end
`ifdef CX_OCC_EN
    check("mid_occ", occ, 0);
`endif
    @(posedge clk); #1;
    send_one(16'h5A5A, 1'b1, 1'b1);
    wait_out(e);
    check("mid_new_latency", e, DP - 1);
    check("mid_new_data", Dout, 16'h5A5A);
    check("mid_new_feb", feb, 1);
    repeat (5) @(negedge clk);
    check("mid_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
